// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive FIFO block.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH    = 2'd1,
    WAITCLR = 2'd2
  } cap_state_e;

  localparam int ENTRY_W        = 9;
  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_TMOBITS    = 16;

  // FIFO entry layout: framing-error tag above the data byte.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic fe, input logic [7:0] data);
    return {fe, data};
  endfunction

endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: head entry is always visible on rd_data_o.
// Storage is not reset; pointers and occupancy count are.
module fifo_fwft #(
  parameter int WIDTH      = 9,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int                  DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_rd, do_wr;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Asynchronous head read gives fall-through behaviour without a prefetch stage.
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive capture FSM + FWFT FIFO with sticky error flags and interrupt.
// Define UART_RXFIFO_TIMEOUT_EN to add the idle-timeout interrupt source.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int TMOBITS    = DEF_TMOBITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            q_in,
  input  logic                  dv_in,
  input  logic                  fe_in,
  input  logic                  ove_in,
  output logic                  rd_core,
  input  logic                  rdfifo,
  output logic [7:0]            dout,
  output logic                  dout_fe,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  input  logic [DEPTH_LOG2:0]   thresh,
  output logic                  err_ovf,
  output logic                  err_fe,
  input  logic                  clrerr,
  output logic                  irq,
  input  logic [TMOBITS-1:0]    tmo_cycles
);

  cap_state_e state_q, state_d;
  logic       push;
  logic       pop_ok;
  logic       drop;
  logic       err_ovf_q, err_ovf_d;
  logic       err_fe_q, err_fe_d;
  logic       irq_q, irq_d;
  logic       tmo_flag;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE:    if (dv_in) state_d = PUSH;
      PUSH: begin
        push    = 1'b1;
        state_d = WAITCLR;
      end
      WAITCLR: if (!dv_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign rd_core = push;
  assign pop_ok  = rdfifo && !empty;
  assign drop    = push && full && !pop_ok;

  fifo_fwft #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (pack_entry(fe_in, q_in)),
    .rd_en_i   (rdfifo),
    .rd_data_o (head),
    .count_o   (count),
    .empty_o   (empty),
    .full_o    (full)
  );

  assign dout    = head[7:0];
  assign dout_fe = head[8];

  // New error events win over a simultaneous clear.
  always_comb begin
    err_ovf_d = (err_ovf_q && !clrerr) || drop || (push && ove_in);
    err_fe_d  = (err_fe_q && !clrerr) || (push && fe_in);
    irq_d     = (count >= thresh) || err_ovf_q || err_fe_q || tmo_flag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_fe_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_fe_q  <= err_fe_d;
      irq_q     <= irq_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_fe  = err_fe_q;
  assign irq     = irq_q;

`ifdef UART_RXFIFO_TIMEOUT_EN
  localparam logic [TMOBITS-1:0] TMO_ONE = 1;

  logic [TMOBITS-1:0] tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;
  logic               tmo_flag_q, tmo_flag_d;

  assign tmo_cnt_inc = tmo_cnt_q + TMO_ONE;

  // Counting stops once the flag is raised, so the counter never wraps.
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
    if (pop_ok) begin
      tmo_cnt_d  = '0;
      tmo_flag_d = 1'b0;
    end else if (empty || push) begin
      tmo_cnt_d = '0;
    end else if (!tmo_flag_q && (tmo_cycles != '0)) begin
      tmo_cnt_d = tmo_cnt_inc;
      if (tmo_cnt_inc == tmo_cycles) tmo_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign tmo_flag = tmo_flag_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^tmo_cycles;
  assign tmo_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model, monitor checks every pop.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int TB    = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   q_in;
  logic         dv_in, fe_in, ove_in;
  logic         rd_core;
  logic         rdfifo;
  logic [7:0]   dout;
  logic         dout_fe, empty, full;
  logic [DL2:0] count;
  logic [DL2:0] thresh;
  logic         err_ovf, err_fe, clrerr, irq;
  logic [TB-1:0] tmo_cycles;

  uart_rx_fifo #(.DEPTH_LOG2(DL2), .TMOBITS(TB)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .dv_in(dv_in), .fe_in(fe_in), .ove_in(ove_in),
    .rd_core(rd_core), .rdfifo(rdfifo), .dout(dout), .dout_fe(dout_fe), .empty(empty),
    .full(full), .count(count), .thresh(thresh), .err_ovf(err_ovf), .err_fe(err_fe),
    .clrerr(clrerr), .irq(irq), .tmo_cycles(tmo_cycles)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  bit         m_ovf = 0;
  bit         m_fe  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rdfifo && !empty) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_unexpected actual=0x%0h required=none", {dout_fe, dout});
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("pop_data", {23'd0, dout_fe, dout}, {23'd0, e});
        end
      end
    end
  end

  task automatic check_state(input string tag);
    bit lvl;
    @(posedge clk);
    @(negedge clk);
    lvl = (exp_q.size() >= int'(thresh)) || m_ovf || m_fe;
    chk({tag, ":count"}, count, exp_q.size());
    chk({tag, ":empty"}, empty, exp_q.size() == 0);
    chk({tag, ":full"},  full,  exp_q.size() == DEPTH);
    chk({tag, ":err_ovf"}, err_ovf, m_ovf);
    chk({tag, ":err_fe"},  err_fe,  m_fe);
    chk({tag, ":irq"}, irq, lvl);
    if (exp_q.size() > 0) chk({tag, ":head"}, {23'd0, dout_fe, dout}, {23'd0, exp_q[0]});
  endtask

  task automatic send_char(input logic [7:0] d, input logic fe, input logic ove,
                           input bit pop_too, input int hold, output int edges_after);
    int sz_pre;
    bit pre_irq;
    @(posedge clk); #1;
    q_in = d; fe_in = fe; ove_in = ove; dv_in = 1'b1;
    @(negedge clk);
    chk("rd_core_idle", rd_core, 0);
    @(posedge clk); #1;
    sz_pre = exp_q.size();
    if (pop_too) rdfifo = 1'b1;
    @(negedge clk);
    chk("rd_core_pulse", rd_core, 1);
    if (!pop_too) chk("count_pre_push", count, sz_pre);
    @(posedge clk);
    pre_irq = (sz_pre >= int'(thresh)) || m_ovf || m_fe;
    if (exp_q.size() < DEPTH) exp_q.push_back({fe, d});
    else m_ovf = 1;
    if (ove) m_ovf = 1;
    if (fe)  m_fe  = 1;
    #1 rdfifo = 1'b0;
    @(negedge clk);
    chk("rd_core_once", rd_core, 0);
    chk("count_post_push", count, exp_q.size());
    chk("irq_lag", irq, pre_irq);
    edges_after = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); edges_after++;
      @(negedge clk);
      chk("rd_core_held", rd_core, 0);
    end
    @(posedge clk); edges_after++;
    #1 dv_in = 1'b0; fe_in = 1'b0; ove_in = 1'b0;
    @(posedge clk); edges_after++;
  endtask

  task automatic send(input logic [7:0] d, input logic fe);
    int e;
    send_char(d, fe, 1'b0, 1'b0, 0, e);
  endtask

  task automatic pop_one();
    @(posedge clk); #1 rdfifo = 1'b1;
    @(posedge clk); #1 rdfifo = 1'b0;
  endtask

  task automatic clear_err();
    @(posedge clk); #1 clrerr = 1'b1;
    @(posedge clk); m_ovf = 0; m_fe = 0;
    #1 clrerr = 1'b0;
  endtask

  task automatic set_thresh(input int v);
    @(posedge clk); #1 thresh = v[DL2:0];
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int e;
    rst = 1'b1; q_in = '0; dv_in = 0; fe_in = 0; ove_in = 0; rdfifo = 0; clrerr = 0;
    thresh = 5'd8; tmo_cycles = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst:count", count, 0);
    chk("rst:empty", empty, 1);
    chk("rst:full", full, 0);
    chk("rst:rd_core", rd_core, 0);
    chk("rst:err_ovf", err_ovf, 0);
    chk("rst:err_fe", err_fe, 0);
    chk("rst:irq", irq, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single character, dv_in held high for several cycles.
    send_char(8'h41, 1'b0, 1'b0, 1'b0, 3, e);
    check_state("single");
    pop_one();
    check_state("single_pop");

    // Fill to full, then overflow.
    for (int i = 0; i < DEPTH; i++) send(i[7:0], 1'b0);
    check_state("full");
    send(8'hAA, 1'b0);
    check_state("overflow");
    for (int i = 0; i < DEPTH; i++) pop_one();
    check_state("drained");
    clear_err();
    check_state("clr_ovf");

    // Push and pop in the same cycle at count 3.
    for (int i = 0; i < 3; i++) send(8'h10 + i[7:0], 1'b0);
    send_char(8'h20, 1'b0, 1'b0, 1'b1, 0, e);
    check_state("push_pop");
    for (int i = 0; i < 3; i++) pop_one();
    check_state("push_pop_drain");

    // Framing-error tag survives clearing of the sticky flag.
    send(8'h55, 1'b1);
    check_state("fe_set");
    clear_err();
    check_state("fe_clr");
    pop_one();
    check_state("fe_pop");

    // Interrupt level threshold.
    set_thresh(4);
    for (int i = 0; i < 3; i++) send(8'h60 + i[7:0], 1'b0);
    check_state("thr3");
    send(8'h63, 1'b0);
    check_state("thr4");
    for (int i = 0; i < 4; i++) pop_one();
    set_thresh(0);
    check_state("thr0");
    set_thresh(8);

    // Reset during PUSH abandons the capture; dv_in still high is then captured.
    @(posedge clk); #1 dv_in = 1'b1; q_in = 8'h33; fe_in = 0; ove_in = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); exp_q.delete(); m_ovf = 0; m_fe = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_abandon:count", count, 0);
    chk("rst_abandon:rd_core", rd_core, 0);
    @(posedge clk);
    @(posedge clk); exp_q.push_back({1'b0, 8'h33});
    #1 dv_in = 1'b0;
    check_state("rst_recapture");
    pop_one();
    check_state("rst_recapture_pop");

`ifdef UART_RXFIFO_TIMEOUT_EN
    begin
      int k;
      set_thresh(17);
      tmo_cycles = 16'd100;
      send_char(8'h77, 1'b0, 1'b0, 1'b0, 0, k);
      while (k < 200) begin
        @(posedge clk); k++;
        @(negedge clk);
        if (irq) break;
      end
      chk("tmo_irq_latency", k, 101);
      pop_one();
      check_state("tmo_clear");
      tmo_cycles = '0;
      set_thresh(8);
    end
`endif

    // Randomized traffic against the queue model.
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        send_char(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2), e);
      end else if (r <= 7) begin
        pop_one();
      end else if (r == 8) begin
        clear_err();
      end else begin
        set_thresh($urandom_range(0, 17));
      end
      check_state("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: the FIFO holds 2**DEPTH_LOG2 entries.
REQ-002 Parameter TMOBITS, default 16: width of the timeout count.
REQ-003 Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- q_in  in  8  received data from the UART core.
- dv_in  in  1  data-valid flag from the UART core.
- fe_in  in  1  framing-error flag from the UART core.
- ove_in  in  1  overrun flag from the UART core.
- rd_core  out  1  one-cycle pulse that clears the core's dv_in.
- rdfifo  in  1  CPU pop strobe.
- dout  out  8  data at the FIFO head.
- dout_fe  out  1  framing-error tag of the head entry.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- count  out  DEPTH_LOG2+1  number of entries in the FIFO.
- thresh  in  DEPTH_LOG2+1  interrupt level.
- err_ovf  out  1  sticky overflow flag.
- err_fe  out  1  sticky framing-error flag.
- clrerr  in  1  clears both sticky flags.
- irq  out  1  interrupt request.
- tmo_cycles  in  TMOBITS  idle timeout length in clk cycles.

Function
REQ-004 The FIFO shall be first-word-fall-through: dout and dout_fe always show the head entry; their value is don't-care when empty=1.
REQ-005 Each entry shall be 9 bits: {fe_in, q_in}.
REQ-006 The capture FSM shall have states IDLE, PUSH and WAITCLR.
REQ-007 IDLE -> PUSH on the first cycle dv_in=1 is sampled.
REQ-008 In PUSH (exactly one cycle), rd_core=1, the word is written if not full, then -> WAITCLR.
REQ-009 In WAITCLR, the FSM shall stay until dv_in=0, then -> IDLE; each received character therefore produces exactly one push.
REQ-010 Capture latency shall be 2 cycles from dv_in rising to count incrementing.
REQ-011 Push while full, with no pop in the same cycle: the word shall be dropped, rd_core still pulsed, and err_ovf set.
REQ-012 Push and pop in the same cycle shall both be performed; count unchanged; legal also when full or empty-after-push is not possible (pop on empty is ignored).
REQ-013 rdfifo while empty shall be ignored, with no pointer or count change.
REQ-014 Read and write pointers shall be DEPTH_LOG2 bits and wrap modulo depth.
REQ-015 count shall be pointer difference maintained as a separate counter.
- full = (count == 2**DEPTH_LOG2).
- empty = (count == 0).
REQ-016 ove_in=1 sampled in PUSH shall set err_ovf.
REQ-017 fe_in=1 sampled in PUSH shall set err_fe.
REQ-018 clrerr shall clear both sticky flags; a set and clrerr in the same cycle resolve to set.
REQ-019 irq shall be registered: irq = (count >= thresh) | err_ovf | err_fe | tmo_flag.
REQ-020 thresh=0 shall force the level term true.

Reset
REQ-021 rst shall drive: FSM=IDLE, pointers=0, count=0, empty=1, full=0, rd_core=0, err_ovf=0, err_fe=0, irq=0, timeout counter=0, tmo_flag=0.
REQ-022 FIFO storage shall not be reset.
REQ-023 rst asserted mid-capture shall abandon the capture with no push; if dv_in is still 1 after reset, it is captured normally.

Configuration
REQ-024 Macro UART_RXFIFO_TIMEOUT_EN defined: an idle counter shall count cycles while empty=0 and no push or pop occurs.
- Any push or pop, or empty=1, resets the counter.
- Reaching tmo_cycles sets tmo_flag (sticky until a pop or rst).
- tmo_cycles=0 disables the timeout.
REQ-025 Macro undefined: no counter is instantiated, tmo_flag is constant 0, and tmo_cycles is unused.

Structure
REQ-026 Shared package uart_pkg shall hold:
- the FSM state enumeration (IDLE, PUSH, WAITCLR);
- the entry width constant (9);
- the default DEPTH_LOG2 and TMOBITS.
REQ-027 The storage array, pointers and count shall live in sub-module fifo_fwft, parameterised by width and depth log2.
REQ-028 The capture FSM, sticky flags, irq and timeout logic shall remain in uart_rx_fifo.

Verification
REQ-029 dv_in held high, q_in=0x41, fe_in=0:
- rd_core pulses once, 1 cycle after dv_in is sampled;
- count becomes 1 two cycles after dv_in rises;
- dout=0x41, dout_fe=0.
REQ-030 Sixteen characters 0x00..0x0F, then a 17th (0xAA):
- full=1, count=16;
- 0xAA dropped, err_ovf=1, rd_core still pulsed;
- pops return 0x00..0x0F in order.
REQ-031 FIFO at count=3 with rdfifo=1 in the PUSH cycle:
- count stays 3;
- head advances by one.
REQ-032 q_in=0x55 with fe_in=1:
- dout_fe=1 and err_fe=1;
- clrerr then gives err_fe=0, while dout_fe stays 1 until the entry is popped.
REQ-033 thresh=4: irq=0 at count 3, irq=1 one cycle after count reaches 4.
REQ-034 UART_RXFIFO_TIMEOUT_EN defined, tmo_cycles=100, one entry, no activity:
- irq=1 after 100 idle cycles;
- a pop clears tmo_flag.
